// File: rtl/xfade_source_mux_if.sv
// Sample-strobed source-select bus between the oscillator bank and the crossfading mux.
interface xfade_source_mux_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4
);
  logic                      i_sample_en;
  logic [SEL_W-1:0]          i_select;
  logic [CHANNELS*WIDTH-1:0] i_data;
  logic [WIDTH-1:0]          o_output;
  logic                      o_valid;
  logic                      o_busy;
  logic [SEL_W-1:0]          o_active_sel;

  modport master (
    output i_sample_en, i_select, i_data,
    input  o_output, o_valid, o_busy, o_active_sel
  );

  modport slave (
    input  i_sample_en, i_select, i_data,
    output o_output, o_valid, o_busy, o_active_sel
  );
endinterface

// File: rtl/xfade_source_mux.sv
// N-channel registered source selector that crossfades linearly over 2^FADE_LOG2
// sample strobes whenever the requested source changes.
module xfade_source_mux #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 16,
  parameter int SEL_W     = 4,
  parameter int FADE_LOG2 = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  xfade_source_mux_if.slave    bus
);
  localparam int N    = 1 << FADE_LOG2;
  localparam int KW   = FADE_LOG2 + 1;
  localparam int WW   = FADE_LOG2 + 2;
  localparam int SW   = WIDTH + WW;
  localparam int NSEL = 1 << SEL_W;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam bit HAS_FADE = (FADE_LOG2 > 0);

  typedef enum logic {IDLE, FADE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [SEL_W-1:0] cur_q, cur_d, tgt_q, tgt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d, busy_q, busy_d;

  // Selector space padded to 2^SEL_W so any select value indexes safely.
  logic signed [WIDTH-1:0] ch [NSEL];
  logic [NSEL-1:0]         sel_in_range;

  generate
    for (genvar c = 0; c < NSEL; c++) begin : g_ch
      if (c < CHANNELS) begin : g_live
        assign ch[c]           = bus.i_data[c*WIDTH +: WIDTH];
        assign sel_in_range[c] = 1'b1;
      end else begin : g_pad
        assign ch[c]           = '0;
        assign sel_in_range[c] = 1'b0;
      end
    end
  endgenerate

  // In IDLE k is 0, so the same mix path yields the pure current source.
  logic [WW-1:0]         w_tgt, w_cur;
  logic signed [SW-1:0]  sum;
  logic [WIDTH-1:0]      mix;

  assign w_tgt = {1'b0, k_q};
  assign w_cur = WW'(N) - w_tgt;
  assign sum   = ch[cur_q] * $signed(w_cur) + ch[tgt_q] * $signed(w_tgt);
  assign mix   = WIDTH'(sum >>> FADE_LOG2);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    out_d   = out_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    if (bus.i_sample_en) begin
      valid_d = 1'b1;
      out_d   = mix;
      case (state_q)
        IDLE: begin
          if (sel_in_range[bus.i_select] && (bus.i_select != cur_q)) begin
            if (HAS_FADE) begin
              tgt_d   = bus.i_select;
              k_d     = KW'(1);
              busy_d  = 1'b1;
              state_d = FADE;
            end else begin
              out_d = ch[bus.i_select];
              cur_d = bus.i_select;
            end
          end
        end
        FADE: begin
          if (k_q == K_LAST) begin
            cur_d   = tgt_q;
            k_d     = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      cur_q   <= '0;
      tgt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_output     = out_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_active_sel = cur_q;
endmodule

// File: tb/tb_xfade_source_mux.sv
// Directed plus randomized bench for two xfade_source_mux builds (fade length 4 and 1)
// checked against a floor-division crossfade reference model.
module tb_xfade_source_mux;
  localparam int W  = 16;
  localparam int CH = 12;
  localparam int SW = 4;

  logic gclk_dummy_unused;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xfade_source_mux_if #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) bus0 ();
  xfade_source_mux_if #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) bus1 ();

  xfade_source_mux #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .FADE_LOG2(2)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave));
  xfade_source_mux #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .FADE_LOG2(0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave));

  int chv [CH];
  int m_cur [2];
  int m_tgt [2];
  int m_k   [2];
  int m_out [2];
  int fl    [2] = '{2, 0};
  int n_pass = 0;
  int n_chk  = 0;

  assign gclk_dummy_unused = 1'b0;

  function automatic int floordiv(int num, int den);
    int q = num / den;
    if ((num % den) != 0 && num < 0) q--;
    return q;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cur[d] = 0; m_tgt[d] = 0; m_k[d] = 0; m_out[d] = 0;
    end
  endfunction

  // A strobe either emits the settled source (and maybe begins a fade) or emits
  // the k/N weighted blend, floored.
  function automatic void model_strobe(int sel);
    for (int d = 0; d < 2; d++) begin
      int n = 1 << fl[d];
      if (m_k[d] == 0) begin
        m_out[d] = chv[m_cur[d]];
        if (sel < CH && sel != m_cur[d]) begin
          if (n == 1) begin
            m_out[d] = chv[sel];
            m_cur[d] = sel;
          end else begin
            m_tgt[d] = sel;
            m_k[d]   = 1;
          end
        end
      end else begin
        m_out[d] = floordiv(chv[m_cur[d]] * (n - m_k[d]) + chv[m_tgt[d]] * m_k[d], n);
        if (m_k[d] == n - 1) begin
          m_cur[d] = m_tgt[d];
          m_k[d]   = 0;
        end else begin
          m_k[d]++;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s dut%0d: got %0h want %0h", tag, d, obs, exp);
    end
  endtask

  task automatic chk_dut(input int d, input logic [W-1:0] o, input logic v, input logic b,
                         input logic [SW-1:0] a, input bit ev);
    chk("output", d, 32'(o), 32'(m_out[d][W-1:0]));
    chk("valid", d, 32'(v), 32'(ev));
    chk("busy", d, 32'(b), 32'(m_k[d] != 0));
    chk("active_sel", d, 32'(a), 32'(m_cur[d]));
  endtask

  task automatic check_all(input bit ev);
    chk_dut(0, bus0.o_output, bus0.o_valid, bus0.o_busy, bus0.o_active_sel, ev);
    chk_dut(1, bus1.o_output, bus1.o_valid, bus1.o_busy, bus1.o_active_sel, ev);
  endtask

  task automatic drive(input int sel, input logic en, input bit junk);
    logic [CH*W-1:0] pk;
    logic [31:0] r;
    for (int c = 0; c < CH; c++) begin
      r = $urandom;
      pk[c*W +: W] = junk ? r[W-1:0] : chv[c][W-1:0];
    end
    bus0.i_data = pk;        bus1.i_data = pk;
    bus0.i_select = SW'(sel); bus1.i_select = SW'(sel);
    bus0.i_sample_en = en;   bus1.i_sample_en = en;
  endtask

  task automatic strobe(input int sel);
    @(negedge clk);
    drive(sel, 1'b1, 1'b0);
    model_strobe(sel);
    @(negedge clk);
    bus0.i_sample_en = 1'b0; bus1.i_sample_en = 1'b0;
    check_all(1'b1);
  endtask

  // Non-strobe cycles with garbage inputs: everything must hold, valid low.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(int'($urandom_range(0, 15)), 1'b0, 1'b1);
      @(negedge clk);
      check_all(1'b0);
    end
  endtask

  task automatic reset_dut(input logic en_during);
    @(negedge clk);
    rst_n = 1'b0;
    drive(int'($urandom_range(1, 11)), en_during, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    bus0.i_sample_en = 1'b0; bus1.i_sample_en = 1'b0;
    model_reset();
    check_all(1'b0);
  endtask

  initial begin
    int sel;
    for (int c = 0; c < CH; c++) chv[c] = 0;
    drive(0, 1'b0, 1'b0);
    model_reset();

    reset_dut(1'b0);
    chv[0] = 'h1234;
    strobe(0);
    idle(1);

    reset_dut(1'b0);
    chv[0] = 4096; chv[1] = 8192;
    repeat (5) strobe(1);

    reset_dut(1'b0);
    chv[0] = -3; chv[1] = 0;
    repeat (5) strobe(1);

    reset_dut(1'b0);
    chv[0] = 100; chv[1] = -2000; chv[2] = 3000;
    strobe(1); strobe(1); strobe(2); strobe(2); strobe(2); strobe(2);

    reset_dut(1'b0);
    chv[0] = 555;
    strobe(13); idle(1); strobe(15); strobe(12);

    reset_dut(1'b0);
    chv[0] = -700; chv[1] = 900;
    strobe(1); strobe(1);
    reset_dut(1'b1);
    strobe(1); strobe(1);

    for (int i = 0; i < 250; i++) begin
      for (int c = 0; c < CH; c++) chv[c] = int'($urandom_range(0, 65535)) - 32768;
      sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      strobe(sel);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
      if ($urandom_range(0, 59) == 0) reset_dut(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
